// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU scalar-multiply datapath: mode bits, FSM encoding
// and elaboration-time index helpers.
package mpu_pkg;

  localparam int MODE_SIGNED = 0;
  localparam int MODE_SAT    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit offset of element (i,j) in a flattened column-major matrix.
  function automatic int at(input int i, input int j, input int dim, input int width);
    return width * (i + dim * j);
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/mpu_scalar_lane.sv
// One combinational multiply lane: full-width product, overflow detection,
// then wrap or saturate to the element width.
module mpu_scalar_lane #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] f,
  input  logic             is_signed,
  input  logic             saturate,
  output logic [WIDTH-1:0] p,
  output logic             ovf
);

  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0] a_s, f_s, prod_s;
  logic        [PW-1:0] a_u, f_u, prod_u;
  logic                 ovf_s, ovf_u;

  function automatic logic [WIDTH-1:0] sat_signed(input logic signed [PW-1:0] x,
                                                  input logic              o);
    if (!o)        return x[WIDTH-1:0];
    if (x[PW-1])   return {1'b1, {(WIDTH-1){1'b0}}};
    return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  function automatic logic [WIDTH-1:0] sat_unsigned(input logic [PW-1:0] x,
                                                    input logic          o);
    if (o) return {WIDTH{1'b1}};
    return x[WIDTH-1:0];
  endfunction

  always_comb begin
    a_s    = {{WIDTH{a[WIDTH-1]}}, a};
    f_s    = {{WIDTH{f[WIDTH-1]}}, f};
    a_u    = {{WIDTH{1'b0}}, a};
    f_u    = {{WIDTH{1'b0}}, f};
    prod_s = a_s * f_s;
    prod_u = a_u * f_u;
    // A signed product fits only if its upper WIDTH+1 bits are a pure sign extension.
    ovf_s  = !((&prod_s[PW-1:WIDTH-1]) || !(|prod_s[PW-1:WIDTH-1]));
    ovf_u  = |prod_u[PW-1:WIDTH];
    if (is_signed) begin
      ovf = ovf_s;
      p   = saturate ? sat_signed(prod_s, ovf_s) : prod_s[WIDTH-1:0];
    end else begin
      ovf = ovf_u;
      p   = saturate ? sat_unsigned(prod_u, ovf_u) : prod_u[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mpu_scalar_mul_seq.sv
// Multi-cycle matrix-by-scalar multiplier: latches a DIM x DIM matrix and a scalar,
// then processes LANES elements per cycle with valid/ready handshakes on both sides.
module mpu_scalar_mul_seq
  import mpu_pkg::*;
#(
  parameter int DIM   = 5,
  parameter int WIDTH = 8,
  parameter int LANES = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH*DIM*DIM-1:0]   matrix_a,
  input  logic [WIDTH-1:0]           factor,
  input  logic [1:0]                 mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*DIM*DIM-1:0]   result,
  output logic                       overflow,
  output logic                       busy
);

  localparam int N_ELEM  = DIM * DIM;
  localparam int FLAT_W  = WIDTH * N_ELEM;
  localparam int N_CHUNK = ceil_div(N_ELEM, LANES);
  localparam int CHUNK_W = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(N_CHUNK - 1);

  state_t               state_q, state_d;
  logic [CHUNK_W-1:0]   chunk_q;
  logic [FLAT_W-1:0]    a_q;
  logic [FLAT_W-1:0]    result_q;
  logic [WIDTH-1:0]     f_q;
  logic [1:0]           mode_q;
  logic                 ovf_q;
  logic                 accept;
  logic                 last_chunk;
  logic                 chunk_ovf;

  int                   lane_idx [LANES];
  logic                 lane_en  [LANES];
  logic [WIDTH-1:0]     lane_a   [LANES];
  logic [WIDTH-1:0]     lane_p   [LANES];
  logic                 lane_ovf [LANES];

  assign accept     = in_valid && (state_q == ST_IDLE);
  assign last_chunk = (chunk_q == LAST_CHUNK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)     state_d = ST_BUSY;
      ST_BUSY: if (last_chunk) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Lane k of the current chunk handles linear element chunk*LANES+k; tail lanes idle.
  always_comb begin
    chunk_ovf = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      lane_idx[k] = int'(chunk_q) * LANES + k;
      lane_en[k]  = (lane_idx[k] < N_ELEM);
      lane_a[k]   = lane_en[k] ? a_q[WIDTH*lane_idx[k] +: WIDTH] : '0;
      chunk_ovf   = chunk_ovf | (lane_en[k] & lane_ovf[k]);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mpu_scalar_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .a        (lane_a[k]),
      .f        (f_q),
      .is_signed(mode_q[MODE_SIGNED]),
      .saturate (mode_q[MODE_SAT]),
      .p        (lane_p[k]),
      .ovf      (lane_ovf[k])
    );
  end

  // Operand snapshot: only the accept edge loads it, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= matrix_a;
      f_q    <= factor;
      mode_q <= mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chunk_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      chunk_q <= '0;
      ovf_q   <= 1'b0;
    end else if (state_q == ST_BUSY) begin
      chunk_q <= last_chunk ? '0 : chunk_q + CHUNK_W'(1);
      ovf_q   <= ovf_q | chunk_ovf;
      for (int k = 0; k < LANES; k++) begin
        if (lane_en[k]) result_q[WIDTH*lane_idx[k] +: WIDTH] <= lane_p[k];
      end
    end
  end

  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mpu_scalar_mul_seq.sv
// Directed bench for mpu_scalar_mul_seq: a LANES=5 instance for most cases and a
// LANES=7 instance for the uneven-chunk case, sharing clock, reset and operands.
module tb_mpu_scalar_mul_seq;
  import mpu_pkg::*;

  localparam int DIM = 5;
  localparam int W   = 8;
  localparam int FW  = W * DIM * DIM;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_valid7;
  logic          in_ready, in_ready7;
  logic [FW-1:0] matrix_a;
  logic [W-1:0]  factor;
  logic [1:0]    mode;
  logic          out_valid, out_valid7;
  logic          out_ready;
  logic [FW-1:0] result, result7;
  logic          overflow, overflow7;
  logic          busy, busy7;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mpu_scalar_mul_seq #(.DIM(DIM), .WIDTH(W), .LANES(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .matrix_a(matrix_a), .factor(factor), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .overflow(overflow), .busy(busy)
  );

  mpu_scalar_mul_seq #(.DIM(DIM), .WIDTH(W), .LANES(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid7), .in_ready(in_ready7),
    .matrix_a(matrix_a), .factor(factor), .mode(mode), .out_valid(out_valid7),
    .out_ready(out_ready), .result(result7), .overflow(overflow7), .busy(busy7)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Element at linear index n = i+DIM*j holds mul*(n+1), truncated to W bits.
  function automatic logic [FW-1:0] ramp(input int mul);
    logic [FW-1:0] m;
    m = '0;
    for (int j = 0; j < DIM; j++)
      for (int i = 0; i < DIM; i++)
        m[at(i, j, DIM, W) +: W] = W'(mul * (i + DIM * j + 1));
    return m;
  endfunction

  function automatic logic [FW-1:0] fill(input logic [W-1:0] v);
    logic [FW-1:0] m;
    for (int n = 0; n < DIM * DIM; n++) m[W*n +: W] = v;
    return m;
  endfunction

  task automatic run5(input logic [FW-1:0] m, input logic [W-1:0] f, input logic [1:0] md,
                      output int lat);
    matrix_a = m; factor = f; mode = md; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run7(input logic [FW-1:0] m, input logic [W-1:0] f, input logic [1:0] md,
                      output int lat);
    matrix_a = m; factor = f; mode = md; in_valid7 = 1'b1;
    @(posedge clk); #1;
    in_valid7 = 1'b0;
    lat = 0;
    while (!out_valid7 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    int            lat;
    logic          seen;
    logic [FW-1:0] m, e;

    rst_n = 1'b0; in_valid = 1'b0; in_valid7 = 1'b0; out_ready = 1'b1;
    matrix_a = '0; factor = '0; mode = 2'b00;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_valid7", out_valid7, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready7", in_ready7, 1);
    check("rst_busy7", busy7, 0);
    step();

    // unsigned wrap, 1..25 x 2
    run5(ramp(1), 8'd2, 2'b00, lat);
    check("u_wrap_latency", lat, 5);
    check("u_wrap_result", result, ramp(2));
    check("u_wrap_ovf", overflow, 0);
    step();
    check("u_wrap_back_idle", in_ready, 1);
    check("u_wrap_out_valid_low", out_valid, 0);
    check("u_wrap_result_kept", result, ramp(2));

    // unsigned saturate, element0 = 200
    m = fill(8'd1); m[7:0] = 8'd200;
    run5(m, 8'd2, 2'b10, lat);
    e = fill(8'd2); e[7:0] = 8'd255;
    check("u_sat_result", result, e);
    check("u_sat_ovf", overflow, 1);
    step();

    // unsigned wrap, element0 = 200 -> 400 mod 256 = 144
    run5(m, 8'd2, 2'b00, lat);
    e[7:0] = 8'd144;
    check("u_wrap200_result", result, e);
    check("u_wrap200_ovf", overflow, 1);
    step();

    // signed saturate: -100, -128 x 2
    m = fill(8'd1); m[7:0] = 8'h9C; m[15:8] = 8'h80;
    run5(m, 8'd2, 2'b11, lat);
    e = fill(8'd2); e[7:0] = 8'h80; e[15:8] = 8'h80;
    check("s_sat_x2_result", result, e);
    check("s_sat_x2_ovf", overflow, 1);
    step();

    // signed saturate: x -1 -> 100, 127, others -1
    run5(m, 8'hFF, 2'b11, lat);
    e = fill(8'hFF); e[7:0] = 8'h64; e[15:8] = 8'h7F;
    check("s_sat_neg1_result", result, e);
    check("s_sat_neg1_ovf", overflow, 1);
    step();

    // signed wrap: -128 * -1 wraps back to -128
    run5(m, 8'hFF, 2'b01, lat);
    e[15:8] = 8'h80;
    check("s_wrap_neg1_result", result, e);
    check("s_wrap_neg1_ovf", overflow, 1);
    step();

    // factor 0 and factor 1
    run5(ramp(1), 8'd0, 2'b00, lat);
    check("f0_result", result, 0);
    check("f0_ovf", overflow, 0);
    step();
    run5(ramp(1), 8'd1, 2'b11, lat);
    check("f1_result", result, ramp(1));
    check("f1_ovf", overflow, 0);
    step();

    // backpressure in DONE with an ignored new request
    out_ready = 1'b0;
    run5(ramp(1), 8'd3, 2'b00, lat);
    check("bp_latency", lat, 5);
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; matrix_a = fill(8'd9); factor = 8'd9;
      step();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", result, ramp(3));
      check("bp_ovf", overflow, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    repeat (7) step();
    check("bp_no_queued_op", busy, 0);
    check("bp_result_kept", result, ramp(3));

    // LANES=7: 4 chunks, last chunk has 4 active lanes
    run7(ramp(1), 8'd3, 2'b00, lat);
    check("l7_latency", lat, 4);
    check("l7_elem24", result7[199:192], 8'd75);
    check("l7_result", result7, ramp(3));
    check("l7_ovf", overflow7, 0);
    step();
    check("l7_back_idle", in_ready7, 1);

    // reset in the second BUSY cycle
    matrix_a = ramp(1); factor = 8'd2; mode = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("mid_busy", busy, 1);
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_busy", busy, 0);
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_out_valid", seen, 0);
    check("mid_rst_in_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
